nes_joypad_device: RTL and testbench

- Emulates two NES controllers (4021 parallel-in/serial-out behaviour) toward an external NES-style host.
- Host drives latch and clock per port; the block returns serial button data.
- Button state is written by the RIPTIDE CPU over an 8-bit register interface.
- Used as a controller source for a real console and for loopback verification of the on-board joypad host.

---
 rtl/nes_joypad_pkg.sv | 31 +++
 rtl/nes_joypad_device_port.sv | 122 ++++++++++++
 rtl/nes_joypad_device.sv | 91 +++++++++
 tb/tb_nes_joypad_device.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_joypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nes_joypad_pkg
// Brief    : Shared constants for the two-port NES controller emulator.
// Revision : 1.0
// ============================================================================
package nes_joypad_pkg;

    // Button bit positions; bit 7 leaves the shift register first.
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam logic [1:0] ADDR_BTN0   = 2'd0;
    localparam logic [1:0] ADDR_BTN1   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_FRAME  = 2'd3;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] FRAME_BITS = 4'd8;

endpackage : nes_joypad_pkg
`default_nettype wire

// File: rtl/nes_joypad_device_port.sv
`default_nettype none
// ============================================================================
// Module   : nes_joypad_device_port
// Brief    : One emulated 4021 port: input conditioning and shift engine.
// Revision : 1.0
// ============================================================================
module nes_joypad_device_port
    import nes_joypad_pkg::*;
#(
    parameter int   FILTER     = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       latch_d,
    input  logic       clk_d,
    input  logic [7:0] buttons,
    output logic       data_q,
    output logic       latch_rise,
    output logic       latch_fall,
    output logic       in_shift
);

    localparam logic [3:0] c_filt_last = 4'(FILTER - 1);

    // Index 0 carries the latch line, index 1 the shift clock line.
    logic [1:0] w_pin;
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic [1:0] r_filt;
    logic [1:0] r_filt_d;

    logic [1:0] r_state;
    logic [7:0] r_shift;
    logic [3:0] r_bits;
    logic [3:0] w_bits_next;
    logic       w_clk_rise;
    logic       r_data_q;

    assign w_pin = {clk_d, latch_d};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_filter
            logic [3:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_meta[g]   <= 1'b0;
                    r_sync[g]   <= 1'b0;
                    r_filt[g]   <= 1'b0;
                    r_filt_d[g] <= 1'b0;
                    r_cnt       <= 4'd0;
                end else begin
                    r_meta[g]   <= w_pin[g];
                    r_sync[g]   <= r_meta[g];
                    r_filt_d[g] <= r_filt[g];
                    // Any return to the accepted level restarts the count.
                    if (r_sync[g] == r_filt[g]) begin
                        r_cnt <= 4'd0;
                    end else if (r_cnt == c_filt_last) begin
                        r_filt[g] <= r_sync[g];
                        r_cnt     <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
            end
        end
    endgenerate

    assign latch_rise  = r_filt[0] & ~r_filt_d[0];
    assign latch_fall  = ~r_filt[0] & r_filt_d[0];
    assign w_clk_rise  = r_filt[1] & ~r_filt_d[1];
    assign w_bits_next = r_bits + 4'd1;

    // Latch level dominates everything, including a coincident clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_shift <= 8'h00;
            r_bits  <= 4'd0;
        end else if (r_filt[0]) begin
            r_state <= ST_LOAD;
            r_shift <= buttons;
            r_bits  <= 4'd0;
        end else if (latch_fall) begin
            r_state <= ST_SHIFT;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_shift <= buttons;
                end
                ST_SHIFT: begin
                    if (w_clk_rise) begin
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_bits  <= w_bits_next;
                        if (w_bits_next == FRAME_BITS) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q <= 1'b1;
        end else if (r_state == ST_DONE) begin
            r_data_q <= IDLE_LEVEL;
        end else begin
            r_data_q <= ~r_shift[BTN_A];
        end
    end

    assign data_q   = r_data_q;
    assign in_shift = (r_state == ST_SHIFT);

endmodule : nes_joypad_device_port
`default_nettype wire

// File: rtl/nes_joypad_device.sv
`default_nettype none
// ============================================================================
// Module   : nes_joypad_device
// Brief    : Two emulated NES controllers with a CPU-side register file.
// Revision : 1.0
// ============================================================================
module nes_joypad_device
    import nes_joypad_pkg::*;
#(
    parameter int   FILTER     = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] latch_d,
    input  logic [1:0] clk_d,
    output logic [1:0] data_q,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic [7:0] from_cpu,
    output logic [7:0] to_cpu
);

    logic [7:0] r_btn [2];
    logic [1:0] w_rise;
    logic [1:0] w_fall;
    logic [1:0] w_in_shift;
    logic [1:0] w_clr;
    logic [1:0] r_seen;
    logic [7:0] r_frame;
    logic [7:0] r_to_cpu;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            nes_joypad_device_port #(
                .FILTER     (FILTER),
                .IDLE_LEVEL (IDLE_LEVEL)
            ) u_port (
                .clk        (clk),
                .rst_n      (rst_n),
                .latch_d    (latch_d[p]),
                .clk_d      (clk_d[p]),
                .buttons    (r_btn[p]),
                .data_q     (data_q[p]),
                .latch_rise (w_rise[p]),
                .latch_fall (w_fall[p]),
                .in_shift   (w_in_shift[p])
            );
        end
    endgenerate

    assign w_clr = (wr && addr == ADDR_STATUS) ? from_cpu[1:0] : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn[0] <= 8'h00;
            r_btn[1] <= 8'h00;
            r_seen   <= 2'b00;
            r_frame  <= 8'h00;
        end else begin
            if (wr && addr == ADDR_BTN0) begin
                r_btn[0] <= from_cpu;
            end
            if (wr && addr == ADDR_BTN1) begin
                r_btn[1] <= from_cpu;
            end
            // A new latch edge outranks a clear landing in the same cycle.
            r_seen <= w_rise | (r_seen & ~w_clr);
            if (w_fall[0]) begin
                r_frame <= r_frame + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cpu <= 8'h00;
        end else begin
            case (addr)
                ADDR_BTN0:   r_to_cpu <= r_btn[0];
                ADDR_BTN1:   r_to_cpu <= r_btn[1];
                ADDR_STATUS: r_to_cpu <= {4'b0000, w_in_shift, r_seen};
                default:     r_to_cpu <= r_frame;
            endcase
        end
    end

    assign to_cpu = r_to_cpu;

endmodule : nes_joypad_device
`default_nettype wire

// File: tb/tb_nes_joypad_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_joypad_device
// Brief    : Directed self-checking bench for nes_joypad_device.
// Revision : 1.0
// ============================================================================
module tb_nes_joypad_device;

    localparam int   FILTER     = 4;
    localparam logic IDLE_LEVEL = 1'b0;
    localparam int   SETTLE     = FILTER + 6;

    logic       clk;
    logic       rst_n;
    logic [1:0] latch_d;
    logic [1:0] clk_d;
    logic [1:0] data_q;
    logic [1:0] addr;
    logic       wr;
    logic [7:0] from_cpu;
    logic [7:0] to_cpu;

    int n_vec;
    int n_err;

    nes_joypad_device #(
        .FILTER     (FILTER),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .latch_d  (latch_d),
        .clk_d    (clk_d),
        .data_q   (data_q),
        .addr     (addr),
        .wr       (wr),
        .from_cpu (from_cpu),
        .to_cpu   (to_cpu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        addr     = a;
        from_cpu = d;
        wr       = 1'b1;
        wait_cyc(1);
        wr       = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        wait_cyc(2);
        d = to_cpu;
    endtask

    task automatic pulse_latch(input int p, input int hi, input int lo);
        latch_d[p] = 1'b1;
        wait_cyc(hi);
        latch_d[p] = 1'b0;
        wait_cyc(lo);
    endtask

    task automatic pulse_clk(input int p);
        clk_d[p] = 1'b1;
        wait_cyc(SETTLE);
        clk_d[p] = 1'b0;
        wait_cyc(SETTLE);
    endtask

    // pins holds the expected active-low pin level before each clock, MSB first.
    task automatic shift_check(input string tag, input int p, input logic [7:0] pins,
                               input int first, input int last);
        for (int k = first; k < last; k++) begin
            check($sformatf("%s_bit%0d", tag, k), {7'd0, data_q[p]}, {7'd0, pins[7-k]});
            pulse_clk(p);
        end
    endtask

    logic [7:0] rd;
    logic [7:0] pins0;
    logic [7:0] pins1;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        latch_d  = 2'b00;
        clk_d    = 2'b00;
        addr     = 2'd0;
        wr       = 1'b0;
        from_cpu = 8'h00;

        wait_cyc(3);
        check("reset_data_q", {6'd0, data_q}, 8'h03);
        check("reset_to_cpu", to_cpu, 8'h00);
        rst_n = 1'b1;
        wait_cyc(2);

        // Basic frame on port 0.
        reg_write(2'd0, 8'hA5);
        pulse_latch(0, SETTLE, SETTLE);
        shift_check("a5", 0, 8'h5A, 0, 8);
        check("a5_idle", {7'd0, data_q[0]}, {7'd0, IDLE_LEVEL});
        reg_read(2'd2, rd);
        check("a5_status", rd, 8'h01);
        reg_read(2'd3, rd);
        check("a5_frame", rd, 8'h01);

        // Latch glitch one cycle short of the filter, then exactly the filter.
        reg_write(2'd2, 8'h03);
        pulse_latch(0, FILTER - 1, SETTLE);
        check("glitch_data_q", {7'd0, data_q[0]}, {7'd0, IDLE_LEVEL});
        reg_read(2'd2, rd);
        check("glitch_status", rd, 8'h00);
        reg_read(2'd3, rd);
        check("glitch_frame", rd, 8'h01);
        pulse_latch(0, FILTER, SETTLE);
        reg_read(2'd2, rd);
        check("accept_status", rd, 8'h05);
        reg_read(2'd3, rd);
        check("accept_frame", rd, 8'h02);

        // Mid-frame write on port 1 does not disturb the frame in progress.
        reg_write(2'd1, 8'h3C);
        pulse_latch(1, SETTLE, SETTLE);
        shift_check("p1_old", 1, 8'hC3, 0, 3);
        reg_write(2'd1, 8'hFF);
        reg_read(2'd2, rd);
        check("p1_status", rd, 8'h0F);
        shift_check("p1_old", 1, 8'hC3, 3, 8);
        check("p1_old_idle", {7'd0, data_q[1]}, {7'd0, IDLE_LEVEL});
        pulse_latch(1, SETTLE, SETTLE);
        shift_check("p1_new", 1, 8'h00, 0, 8);

        // Abort after four clocks with a clock edge coincident with the latch.
        reg_write(2'd0, 8'hC3);
        pulse_latch(0, SETTLE, SETTLE);
        shift_check("abort_pre", 0, 8'h3C, 0, 4);
        check("abort_before", {7'd0, data_q[0]}, 8'h01);
        latch_d[0] = 1'b1;
        clk_d[0]   = 1'b1;
        wait_cyc(SETTLE);
        check("abort_load", {7'd0, data_q[0]}, 8'h00);
        latch_d[0] = 1'b0;
        clk_d[0]   = 1'b0;
        wait_cyc(SETTLE);
        shift_check("abort_full", 0, 8'h3C, 0, 8);
        check("abort_idle", {7'd0, data_q[0]}, {7'd0, IDLE_LEVEL});
        reg_read(2'd3, rd);
        check("abort_frame", rd, 8'h04);

        // Frame count register is read-only.
        reg_write(2'd3, 8'h55);
        reg_read(2'd3, rd);
        check("frame_ro", rd, 8'h04);

        // Both ports concurrently with offset timing.
        reg_write(2'd0, 8'h81);
        reg_write(2'd1, 8'h7E);
        latch_d[0] = 1'b1;
        wait_cyc(3);
        latch_d[1] = 1'b1;
        wait_cyc(SETTLE);
        latch_d[0] = 1'b0;
        wait_cyc(3);
        latch_d[1] = 1'b0;
        wait_cyc(SETTLE);
        pins0 = 8'h7E;
        pins1 = 8'h81;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("dual_p0_bit%0d", k), {7'd0, data_q[0]}, {7'd0, pins0[7-k]});
            check($sformatf("dual_p1_bit%0d", k), {7'd0, data_q[1]}, {7'd0, pins1[7-k]});
            clk_d = 2'b01;
            wait_cyc(3);
            clk_d = 2'b11;
            wait_cyc(SETTLE);
            clk_d = 2'b10;
            wait_cyc(3);
            clk_d = 2'b00;
            wait_cyc(SETTLE);
        end
        check("dual_idle", {6'd0, data_q}, {6'd0, IDLE_LEVEL, IDLE_LEVEL});
        reg_read(2'd2, rd);
        check("dual_status", rd, 8'h03);
        reg_write(2'd2, 8'h03);
        reg_read(2'd2, rd);
        check("clear_status", rd, 8'h00);
        reg_read(2'd3, rd);
        check("dual_frame", rd, 8'h05);

        // Frame counter wraps.
        for (int i = 0; i < 250; i++) begin
            pulse_latch(0, 8, 8);
        end
        wait_cyc(SETTLE);
        reg_read(2'd3, rd);
        check("frame_ff", rd, 8'hFF);
        pulse_latch(0, 8, SETTLE);
        reg_read(2'd3, rd);
        check("frame_wrap", rd, 8'h00);

        // Asynchronous reset in the middle of a frame.
        pulse_clk(0);
        pulse_clk(0);
        addr = 2'd0;
        wait_cyc(2);
        check("pre_reset_to_cpu", to_cpu, 8'h81);
        rst_n = 1'b0;
        #1;
        check("async_data_q", {6'd0, data_q}, 8'h03);
        check("async_to_cpu", to_cpu, 8'h00);
        wait_cyc(2);
        rst_n = 1'b1;
        reg_read(2'd0, rd);
        check("post_reset_btn0", rd, 8'h00);
        reg_read(2'd1, rd);
        check("post_reset_btn1", rd, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_nes_joypad_device
`default_nettype wire
